// File: rtl/external_link_mux_pkg.sv
// Shared decoder-stage constants and link sizing helpers
// for the external link mux and the partition top.
package external_link_mux_pkg;

    localparam int STAGE_WIDTH = 3;

    typedef logic [STAGE_WIDTH-1:0] stage_t;

    localparam stage_t STAGE_IDLE                = 3'd0;
    localparam stage_t STAGE_MEASUREMENT_LOADING = 3'd1;
    localparam stage_t STAGE_SPREAD              = 3'd2;
    localparam stage_t STAGE_GROW                = 3'd3;
    localparam stage_t STAGE_MERGE               = 3'd4;
    localparam stage_t STAGE_PEELING             = 3'd5;

    function automatic int fifo_data_size(input int address_width);
        return address_width + 4;
    endfunction

    function automatic int link_id_width(input int num_links);
        return (num_links <= 2) ? 1 : $clog2(num_links);
    endfunction

endpackage

// File: rtl/external_link_mux_if.sv
// Link-side, TX-side and RX-side handshakes of the external link mux.
// master = mux side, slave = links/transceiver side.
interface external_link_mux_if
    import external_link_mux_pkg::*;
#(
    parameter int NUM_LINKS     = 4,
    parameter int ADDRESS_WIDTH = 6
);
    localparam int FDS = fifo_data_size(ADDRESS_WIDTH);
    localparam int IDW = link_id_width(NUM_LINKS);
    localparam int PKT = IDW + FDS;

    logic [NUM_LINKS*FDS-1:0] link_out_data;
    logic [NUM_LINKS-1:0]     link_out_valid;
    logic [NUM_LINKS-1:0]     link_out_ready;
    logic [NUM_LINKS*FDS-1:0] link_in_data;
    logic [NUM_LINKS-1:0]     link_in_valid;
    logic [NUM_LINKS-1:0]     link_in_ready;
    logic [PKT-1:0]           tx_data;
    logic                     tx_valid;
    logic                     tx_ready;
    logic [PKT-1:0]           rx_data;
    logic                     rx_valid;
    logic                     rx_ready;

    modport master (
        input  link_out_data, link_out_valid,
        output link_out_ready,
        output link_in_data, link_in_valid,
        input  link_in_ready,
        output tx_data, tx_valid,
        input  tx_ready,
        input  rx_data, rx_valid,
        output rx_ready
    );

    modport slave (
        output link_out_data, link_out_valid,
        input  link_out_ready,
        input  link_in_data, link_in_valid,
        output link_in_ready,
        input  tx_data, tx_valid,
        output tx_ready,
        output rx_data, rx_valid,
        input  rx_ready
    );

endinterface

// File: rtl/external_link_mux_sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO with flush.
// Pushes when full and pops when empty are ignored.
module sync_fifo_fwft #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rptr];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= din;
    end

endmodule

// File: rtl/external_link_mux.sv
// Round-robin mux of external link FIFOs onto one tagged TX stream,
// and demux of the peer's RX stream back onto the link inputs.
module external_link_mux
    import external_link_mux_pkg::*;
#(
    parameter int NUM_LINKS     = 4,
    parameter int ADDRESS_WIDTH = 6,
    parameter int TX_FIFO_DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [STAGE_WIDTH-1:0] global_stage,
    external_link_mux_if.master    lnk,
    output logic                   busy,
    output logic                   rx_bad_id
);
    localparam int FDS = fifo_data_size(ADDRESS_WIDTH);
    localparam int IDW = link_id_width(NUM_LINKS);
    localparam int PKT = IDW + FDS;

    logic                 flush;
    logic [IDW-1:0]       rr_ptr;
    logic [NUM_LINKS-1:0] gnt;
    logic                 gnt_any;
    logic [IDW-1:0]       gnt_id;
    logic [FDS-1:0]       gnt_data;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [PKT-1:0]       fifo_dout;
    logic                 tx_pop;
    int                   idx;

    assign flush = (global_stage == STAGE_MEASUREMENT_LOADING);

    // Scan starts just after the last winner so every link gets a turn.
    always_comb begin
        gnt      = '0;
        gnt_any  = 1'b0;
        gnt_id   = '0;
        gnt_data = '0;
        idx      = 0;
        if (!reset && !flush && !fifo_full) begin
            for (int k = 1; k <= NUM_LINKS; k++) begin
                idx = (int'(rr_ptr) + k) % NUM_LINKS;
                if (!gnt_any && lnk.link_out_valid[idx]) begin
                    gnt_any   = 1'b1;
                    gnt[idx]  = 1'b1;
                    gnt_id    = IDW'(idx);
                    gnt_data  = lnk.link_out_data[idx*FDS +: FDS];
                end
            end
        end
    end

    assign lnk.link_out_ready = gnt;

    always_ff @(posedge clk) begin
        if (reset || flush) rr_ptr <= IDW'(NUM_LINKS - 1);
        else if (gnt_any)   rr_ptr <= gnt_id;
    end

    sync_fifo_fwft #(
        .WIDTH (PKT),
        .DEPTH (TX_FIFO_DEPTH)
    ) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .push  (gnt_any),
        .pop   (tx_pop),
        .din   ({gnt_id, gnt_data}),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign lnk.tx_valid = !fifo_empty && !reset;
    assign lnk.tx_data  = fifo_dout;
    assign tx_pop       = lnk.tx_valid && lnk.tx_ready;

    logic           rv;
    logic [IDW-1:0] rid;
    logic [FDS-1:0] rpay;
    logic           rid_ready;
    logic           rx_accept;
    logic           rx_deliver;
    logic [IDW-1:0] rx_id;
    logic           rx_id_ok;

    always_comb begin
        rid_ready = 1'b0;
        for (int i = 0; i < NUM_LINKS; i++)
            if (rid == IDW'(i)) rid_ready = lnk.link_in_ready[i];
    end

    assign rx_id        = lnk.rx_data[PKT-1 -: IDW];
    assign rx_id_ok     = (int'(rx_id) < NUM_LINKS);
    assign lnk.rx_ready = !reset && (flush || !rv || rid_ready);
    assign rx_accept    = lnk.rx_valid && lnk.rx_ready;
    assign rx_deliver   = rv && rid_ready && !flush;

    // Flush drains the peer stream but keeps nothing from the old round.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rv        <= 1'b0;
            rid       <= '0;
            rpay      <= '0;
            rx_bad_id <= 1'b0;
        end else begin
            if (rx_deliver) rv <= 1'b0;
            if (rx_accept) begin
                if (rx_id_ok) begin
                    rv   <= 1'b1;
                    rid  <= rx_id;
                    rpay <= lnk.rx_data[FDS-1:0];
                end else begin
                    rx_bad_id <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        lnk.link_in_valid = '0;
        lnk.link_in_data  = '0;
        if (rv && !reset && !flush) begin
            for (int i = 0; i < NUM_LINKS; i++) begin
                if (rid == IDW'(i)) begin
                    lnk.link_in_valid[i]           = 1'b1;
                    lnk.link_in_data[i*FDS +: FDS] = rpay;
                end
            end
        end
    end

    assign busy = !reset && (!fifo_empty || (|lnk.link_out_valid)
                             || lnk.rx_valid || rv);

endmodule
